// File: rtl/instr_prefetch_queue_if.sv
// Bus bundle between the prefetch queue, the instruction RAM, the decode stage
// and the sequencing controls. The master modport is the prefetch queue side.
interface instr_prefetch_queue_if #(
   parameter int instr_width = 32,
   parameter int n_blocks    = 256,
   parameter int depth       = 4
);
   localparam int AW = $clog2(n_blocks);
   localparam int OW = $clog2(depth) + 1;

   // sequencing controls
   logic                   enable;
   logic                   sample_tick;
   logic                   frame_mode;
   logic                   flush;
   logic [AW-1:0]          n_blocks_running;
   logic [AW-1:0]          last_block;

   // instruction RAM read port
   logic [AW-1:0]          instr_read_addr;
   logic [instr_width-1:0] instr_read_val;

   // decode-side stream
   logic                   out_valid;
   logic                   out_ready;
   logic [instr_width-1:0] out_instr;
   logic [AW-1:0]          out_block;
   logic                   out_last;

   // status
   logic                   pass_done;
   logic                   overrun;
   logic [OW-1:0]          occupancy;

   modport master (
      input  enable, sample_tick, frame_mode, flush, n_blocks_running, last_block,
      input  instr_read_val, out_ready,
      output instr_read_addr, out_valid, out_instr, out_block, out_last,
      output pass_done, overrun, occupancy
   );

   modport slave (
      output enable, sample_tick, frame_mode, flush, n_blocks_running, last_block,
      output instr_read_val, out_ready,
      input  instr_read_addr, out_valid, out_instr, out_block, out_last,
      input  pass_done, overrun, occupancy
   );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: walks the block list issuing instruction RAM
// reads under a credit limit, drops NOP words on return, and buffers the rest
// in a first-word-fall-through queue for the decode stage.
`ifndef BLOCK_INSTR_NOP
`define BLOCK_INSTR_NOP 5'd0
`endif

module instr_prefetch_queue #(
   parameter int instr_width  = 32,
   parameter int n_blocks     = 256,
   parameter int depth        = 4,
   parameter int read_latency = 1
) (
   input  logic clk,
   input  logic reset,
   instr_prefetch_queue_if.master bus
);
   localparam int AW = $clog2(n_blocks);
   localparam int OW = $clog2(depth) + 1;
   localparam int PW = $clog2(depth);
   localparam logic [OW:0]   DEPTH_C  = (OW+1)'(depth);
   localparam logic [OW-1:0] FULL_C   = OW'(depth);
   localparam logic [AW-1:0] MAX_ADDR = AW'(n_blocks - 1);
   localparam logic [4:0]    NOP_OP   = `BLOCK_INSTR_NOP;

   // ST_INIT lasts one cycle after reset so frame_mode is captured from a
   // register load rather than used as an asynchronous reset value.
   typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_WAIT_TICK} state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic                   r_frame_mode;
   logic                   r_pass_done;
   logic                   w_pass_done_next;
   logic                   r_overrun;
   logic                   w_set_overrun;
   logic [AW-1:0]          r_addr;
   logic [AW-1:0]          w_addr_next;
   logic                   w_addr_is_last;
   logic                   w_issue;

   // read tags travelling alongside the RAM latency
   logic [read_latency-1:0] r_tag_valid;
   logic [AW-1:0]          r_tag_addr [read_latency];
   logic [read_latency-1:0] r_tag_last;
   logic [OW-1:0]          r_inflight;
   logic                   w_exit_valid;
   logic                   w_push;
   logic                   w_pop;

   // queue storage and bookkeeping
   logic [instr_width-1:0] r_q_instr [depth];
   logic [AW-1:0]          r_q_block [depth];
   logic [depth-1:0]       r_q_last;
   logic [PW-1:0]          r_wr_ptr;
   logic [PW-1:0]          r_rd_ptr;
   logic [OW-1:0]          r_count;

   assign w_addr_is_last = (r_addr == bus.last_block);
   // addresses past last_block run on to the top of the table, then wrap
   assign w_addr_next    = (w_addr_is_last || r_addr == MAX_ADDR) ? '0 : r_addr + AW'(1);
   // credit: queued plus outstanding reads must leave room for every return
   assign w_issue = bus.enable && (bus.n_blocks_running != '0) && (r_state == ST_RUN) &&
                    (({1'b0, r_count} + {1'b0, r_inflight}) < DEPTH_C);

   assign w_exit_valid = r_tag_valid[read_latency-1];
   assign w_push = w_exit_valid && (bus.instr_read_val[4:0] != NOP_OP);
   assign w_pop  = (r_count != '0) && bus.out_ready;

   // next-state and pulse logic for the pass sequencer
   always_comb begin
      w_state_next     = r_state;
      w_pass_done_next = 1'b0;
      w_set_overrun    = 1'b0;
      case (r_state)
         ST_INIT: w_state_next = bus.frame_mode ? ST_WAIT_TICK : ST_RUN;
         ST_RUN: begin
            if (r_frame_mode && bus.sample_tick) w_set_overrun = 1'b1;
            if (r_frame_mode && w_issue && w_addr_is_last) begin
               w_state_next     = ST_WAIT_TICK;
               w_pass_done_next = 1'b1;
            end
         end
         ST_WAIT_TICK: if (bus.sample_tick) w_state_next = ST_RUN;
         default: w_state_next = ST_INIT;
      endcase
      if (bus.flush) begin
         w_state_next     = bus.frame_mode ? ST_WAIT_TICK : ST_RUN;
         w_pass_done_next = 1'b0;
      end
   end

   // sequencer state, mode latch, pass_done pulse and sticky overrun
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_INIT;
         r_frame_mode <= 1'b0;
         r_pass_done  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_pass_done <= w_pass_done_next;
         if (r_state == ST_INIT || bus.flush) r_frame_mode <= bus.frame_mode;
         if (w_set_overrun) r_overrun <= 1'b1;
      end
   end

   // read address walks the block list, one step per issued read
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_addr <= '0;
      else if (bus.flush) r_addr <= '0;
      else if (w_issue)   r_addr <= w_addr_next;
   end

   // tag shift pipe matching the RAM latency; flush kills stale reads
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tag_valid <= '0;
         r_tag_last  <= '0;
         for (int i = 0; i < read_latency; i++) r_tag_addr[i] <= '0;
      end else if (bus.flush) begin
         r_tag_valid <= '0;
      end else begin
         r_tag_valid[0] <= w_issue;
         r_tag_addr[0]  <= r_addr;
         r_tag_last[0]  <= w_addr_is_last;
         for (int i = 1; i < read_latency; i++) begin
            r_tag_valid[i] <= r_tag_valid[i-1];
            r_tag_addr[i]  <= r_tag_addr[i-1];
            r_tag_last[i]  <= r_tag_last[i-1];
         end
      end
   end

   // outstanding read count: up on issue, down when the tag leaves the pipe
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_inflight <= '0;
      else if (bus.flush) r_inflight <= '0;
      else begin
         case ({w_issue, w_exit_valid})
            2'b10:   r_inflight <= r_inflight + OW'(1);
            2'b01:   r_inflight <= r_inflight - OW'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // queue storage write; no reset so it maps onto plain memory
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_instr[r_wr_ptr] <= bus.instr_read_val;
         r_q_block[r_wr_ptr] <= r_tag_addr[read_latency-1];
         r_q_last[r_wr_ptr]  <= r_tag_last[read_latency-1];
      end
   end

   // queue pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + OW'(1);
            2'b01:   r_count <= r_count - OW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // the credit rule makes a push into a full queue impossible
   always_ff @(posedge clk) begin
      if (!reset && !bus.flush) assert (!(w_push && r_count == FULL_C));
   end

   assign bus.instr_read_addr = r_addr;
   assign bus.out_valid       = (r_count != '0);
   assign bus.out_instr       = r_q_instr[r_rd_ptr];
   assign bus.out_block       = r_q_block[r_rd_ptr];
   assign bus.out_last        = r_q_last[r_rd_ptr];
   assign bus.pass_done       = r_pass_done;
   assign bus.overrun         = r_overrun;
   assign bus.occupancy       = r_count;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: RAM model with matching latency,
// a negedge monitor logging every decode handshake, hand-computed sequences.
module tb_instr_prefetch_queue;
   localparam int IW = 32;
   localparam int NB = 16;
   localparam int DP = 4;
   localparam int RL = 2;
   localparam int AW = 4;
   localparam logic [4:0] NOP_OP = 5'd0;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   pass_cnt = 0;

   logic [IW-1:0] ram [NB];
   logic [IW-1:0] r_ram_pipe [RL];

   logic [AW-1:0] got_blk [$];
   logic [IW-1:0] got_ins [$];
   logic          got_last [$];
   int            got_cyc [$];

   instr_prefetch_queue_if #(.instr_width(IW), .n_blocks(NB), .depth(DP)) u_if ();

   instr_prefetch_queue #(.instr_width(IW), .n_blocks(NB), .depth(DP), .read_latency(RL))
      u_dut (.clk(clk), .reset(reset), .bus(u_if.master));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // instruction RAM with RL cycles from address to data
   always @(posedge clk) begin
      r_ram_pipe[0] <= ram[u_if.instr_read_addr];
      for (int i = 1; i < RL; i++) r_ram_pipe[i] <= r_ram_pipe[i-1];
   end
   assign u_if.instr_read_val = r_ram_pipe[RL-1];

   // log every handshake that will complete at the next rising edge
   always @(negedge clk) begin
      if (!reset) begin
         if (u_if.out_valid && u_if.out_ready) begin
            got_blk.push_back(u_if.out_block);
            got_ins.push_back(u_if.out_instr);
            got_last.push_back(u_if.out_last);
            got_cyc.push_back(cyc);
            $display("txn cyc=%0d blk=%0d instr=%08h last=%0b", cyc, u_if.out_block,
                     u_if.out_instr, u_if.out_last);
         end
         if (u_if.pass_done) pass_cnt <= pass_cnt + 1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [IW-1:0] mk(input int b, input bit nop);
      logic [26:0] hi;
      logic [4:0]  op;
      hi = 27'(b + 256);
      op = nop ? NOP_OP : 5'(b + 1);
      return {hi, op};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_flush();
      u_if.flush = 1'b1;
      tick_n(1);
      u_if.flush = 1'b0;
   endtask

   task automatic wait_outs(input int base, input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (got_blk.size() < base + n && k < budget) begin
         tick_n(1);
         k++;
      end
      check(tag, 64'(got_blk.size() - base), 64'(n));
   endtask

   task automatic load_ram(input int nop_a, input int nop_b);
      for (int i = 0; i < NB; i++) ram[i] = mk(i, (i == nop_a) || (i == nop_b));
   endtask

   initial begin
      int base;
      int pc0;
      int eb;
      load_ram(-1, -1);
      for (int i = 0; i < RL; i++) r_ram_pipe[i] = '0;
      u_if.enable = 1'b0;
      u_if.sample_tick = 1'b0;
      u_if.frame_mode = 1'b0;
      u_if.flush = 1'b0;
      u_if.n_blocks_running = 4'd1;
      u_if.last_block = 4'd3;
      u_if.out_ready = 1'b1;

      // reset state
      tick_n(3);
      check("rst_valid", 64'(u_if.out_valid), 64'd0);
      check("rst_occ", 64'(u_if.occupancy), 64'd0);
      check("rst_addr", 64'(u_if.instr_read_addr), 64'd0);
      check("rst_pass_done", 64'(u_if.pass_done), 64'd0);
      check("rst_overrun", 64'(u_if.overrun), 64'd0);
      reset = 1'b0;
      tick_n(2);

      // free-running wrap over blocks 0..3 at full rate
      base = got_blk.size();
      u_if.enable = 1'b1;
      wait_outs(base, 12, 60, "free_count");
      for (int i = 0; i < 12 && base + i < got_blk.size(); i++) begin
         eb = i % 4;
         check($sformatf("free_blk%0d", i), 64'(got_blk[base+i]), 64'(eb));
         check($sformatf("free_ins%0d", i), 64'(got_ins[base+i]), 64'(mk(eb, 0)));
         check($sformatf("free_last%0d", i), 64'(got_last[base+i]), 64'(eb == 3));
         if (i > 0) check($sformatf("free_gap%0d", i),
                          64'(got_cyc[base+i] - got_cyc[base+i-1]), 64'd1);
      end

      // NOP blocks 1 and 2 are dropped
      u_if.enable = 1'b0;
      load_ram(1, 2);
      do_flush();
      base = got_blk.size();
      u_if.enable = 1'b1;
      wait_outs(base, 8, 60, "nop_count");
      for (int i = 0; i < 8 && base + i < got_blk.size(); i++) begin
         eb = (i % 2 == 1) ? 3 : 0;
         check($sformatf("nop_blk%0d", i), 64'(got_blk[base+i]), 64'(eb));
         check($sformatf("nop_ins%0d", i), 64'(got_ins[base+i]), 64'(mk(eb, 0)));
      end

      // backpressure: queue fills to depth, address freezes, nothing lost
      u_if.enable = 1'b0;
      u_if.out_ready = 1'b0;
      u_if.last_block = 4'd7;
      load_ram(-1, -1);
      do_flush();
      u_if.enable = 1'b1;
      tick_n(10);
      check("bp_occ_a", 64'(u_if.occupancy), 64'd4);
      check("bp_addr_a", 64'(u_if.instr_read_addr), 64'd4);
      tick_n(10);
      check("bp_occ_b", 64'(u_if.occupancy), 64'd4);
      check("bp_addr_b", 64'(u_if.instr_read_addr), 64'd4);
      check("bp_head", 64'(u_if.out_block), 64'd0);
      base = got_blk.size();
      u_if.out_ready = 1'b1;
      wait_outs(base, 8, 40, "bp_count");
      for (int i = 0; i < 8 && base + i < got_blk.size(); i++)
         check($sformatf("bp_blk%0d", i), 64'(got_blk[base+i]), 64'(i));

      // frame mode: one pass of 0..2 per sample_tick
      u_if.enable = 1'b0;
      u_if.frame_mode = 1'b1;
      u_if.last_block = 4'd2;
      do_flush();
      u_if.enable = 1'b1;
      pc0 = pass_cnt;
      base = got_blk.size();
      tick_n(5);
      check("frm_idle_outs", 64'(got_blk.size() - base), 64'd0);
      check("frm_idle_addr", 64'(u_if.instr_read_addr), 64'd0);
      for (int p = 0; p < 2; p++) begin
         base = got_blk.size();
         u_if.sample_tick = 1'b1;
         tick_n(1);
         u_if.sample_tick = 1'b0;
         wait_outs(base, 3, 30, $sformatf("frm%0d_count", p));
         tick_n(8);
         check($sformatf("frm%0d_total", p), 64'(got_blk.size() - base), 64'd3);
         for (int i = 0; i < 3 && base + i < got_blk.size(); i++)
            check($sformatf("frm%0d_blk%0d", p, i), 64'(got_blk[base+i]), 64'(i));
         if (base + 2 < got_blk.size())
            check($sformatf("frm%0d_last", p), 64'(got_last[base+2]), 64'd1);
         check($sformatf("frm%0d_pass", p), 64'(pass_cnt - pc0), 64'(p + 1));
         check($sformatf("frm%0d_addr", p), 64'(u_if.instr_read_addr), 64'd0);
         check($sformatf("frm%0d_ovr", p), 64'(u_if.overrun), 64'd0);
      end

      // tick during a pass: overrun, no restart
      u_if.last_block = 4'd7;
      base = got_blk.size();
      u_if.sample_tick = 1'b1;
      tick_n(1);
      u_if.sample_tick = 1'b0;
      tick_n(1);
      u_if.sample_tick = 1'b1;
      tick_n(1);
      u_if.sample_tick = 1'b0;
      wait_outs(base, 8, 40, "ovr_count");
      tick_n(10);
      check("ovr_total", 64'(got_blk.size() - base), 64'd8);
      for (int i = 0; i < 8 && base + i < got_blk.size(); i++)
         check($sformatf("ovr_blk%0d", i), 64'(got_blk[base+i]), 64'(i));
      check("ovr_flag", 64'(u_if.overrun), 64'd1);
      check("ovr_pass", 64'(pass_cnt - pc0), 64'd3);

      // flush with entries queued and reads in flight
      u_if.enable = 1'b0;
      u_if.out_ready = 1'b0;
      u_if.frame_mode = 1'b0;
      do_flush();
      check("flush_keeps_overrun", 64'(u_if.overrun), 64'd1);
      u_if.enable = 1'b1;
      for (int k = 0; k < 20 && u_if.occupancy != 3'd2; k++) tick_n(1);
      check("fl_fill", 64'(u_if.occupancy), 64'd2);
      check("fl_inflight_addr", 64'(u_if.instr_read_addr), 64'd4);
      u_if.flush = 1'b1;
      tick_n(1);
      u_if.flush = 1'b0;
      check("fl_occ", 64'(u_if.occupancy), 64'd0);
      check("fl_valid", 64'(u_if.out_valid), 64'd0);
      base = got_blk.size();
      u_if.out_ready = 1'b1;
      wait_outs(base, 4, 30, "fl_count");
      for (int i = 0; i < 4 && base + i < got_blk.size(); i++)
         check($sformatf("fl_blk%0d", i), 64'(got_blk[base+i]), 64'(i));

      // asynchronous reset in the middle of a cycle
      tick_n(3);
      check("ar_pre_valid", 64'(u_if.out_valid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check("ar_valid", 64'(u_if.out_valid), 64'd0);
      check("ar_occ", 64'(u_if.occupancy), 64'd0);
      check("ar_addr", 64'(u_if.instr_read_addr), 64'd0);
      check("ar_pass_done", 64'(u_if.pass_done), 64'd0);
      check("ar_overrun", 64'(u_if.overrun), 64'd0);
      tick_n(2);
      reset = 1'b0;
      base = got_blk.size();
      wait_outs(base, 2, 30, "ar_resume_count");
      for (int i = 0; i < 2 && base + i < got_blk.size(); i++)
         check($sformatf("ar_blk%0d", i), 64'(got_blk[base+i]), 64'(i));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
